cla_linear_recombine_pipe: RTL and testbench

//  Linear half of the decomposed CLA: consumes the nonlinear term vector n
//  (AND products of p/g chains) produced by the nonlinear stage and recombines
//  it with OR/XOR into sum, carry-out and signed overflow.
//  2-stage valid/ready pipeline with a frame-consistency checker and a result counter.

---
 rtl/cla_linear_recombine_pipe.sv | 152 +++++++++++++++
 tb/tb_cla_linear_recombine_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_linear_recombine_pipe.sv
// Linear half of a decomposed carry-lookahead adder.
// Takes the nonlinear AND-term frame n and ORs each carry group into c_k.
// It then XORs the carries with the propagate bits to form sum, carry-out and
// signed overflow. The datapath is a 2-stage valid/ready pipeline. A sticky
// checker flags inconsistent frames, and a wrapping counter counts delivered
// results.
module cla_linear_recombine_pipe #(
    parameter int NBIT = 4,
    // Must equal NBIT + NBIT*(NBIT+3)/2 + 1 (p bits, carry groups, c_in).
    parameter int NNL  = NBIT + NBIT*(NBIT+3)/2 + 1,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NNL-1:0]  n,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] sum,
    output logic            c_out,
    output logic            ovf,
    output logic            frame_err,
    output logic [CNTW-1:0] res_cnt
);

    // Carries recovered from the incoming frame: c_frame[0] is c_in.
    logic [NBIT:0]   c_frame;
    // chk_bad[k] flags a group whose carry-chain term disagrees with the
    // previous group's term.
    logic [NBIT:1]   chk_bad;

    // Stage 1 state
    logic            s1_v_q, s1_v_d;
    logic [NBIT-1:0] p_q, p_d;
    logic [NBIT:0]   c_q, c_d;

    // Stage 2 state
    logic            out_valid_q, out_valid_d;
    logic [NBIT-1:0] sum_q, sum_d;
    logic            c_out_q, c_out_d;
    logic            ovf_q, ovf_d;

    // Bookkeeping
    logic            frame_err_q, frame_err_d;
    logic [CNTW-1:0] res_cnt_q, res_cnt_d;

    // Handshake qualifiers
    logic            s1_load;
    logic            s2_load;
    logic            in_xfer;
    logic            out_xfer;

    assign c_frame[0] = n[NNL-1];

    genvar gi;
    generate
        for (gi = 1; gi <= NBIT; gi++) begin : g_group
            // Group gi occupies gi+1 bits starting at OFF.
            // Its top bit is the c_in-through-all-propagates term.
            localparam int OFF = NBIT + (gi - 1) * (gi + 2) / 2;

            assign c_frame[gi] = |n[OFF + gi : OFF];

            if (gi == 1) begin : g_chk_first
                assign chk_bad[gi] = n[OFF + 1] != (n[NNL-1] & n[0]);
            end else begin : g_chk_chain
                localparam int OFFP = NBIT + (gi - 2) * (gi + 1) / 2;
                assign chk_bad[gi] = n[OFF + gi] != (n[OFFP + gi - 1] & n[gi - 1]);
            end
        end
    endgenerate

    // Next-state logic for both stages, the sticky error flag and the counter.
    always_comb begin
        s2_load     = !out_valid_q | out_ready;
        s1_load     = !s1_v_q | s2_load;
        in_xfer     = in_valid & s1_load;
        out_xfer    = out_valid_q & out_ready;

        s1_v_d      = s1_v_q;
        p_d         = p_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        frame_err_d = frame_err_q;
        res_cnt_d   = res_cnt_q;

        if (s1_load) begin
            s1_v_d = in_valid;
        end
        if (in_xfer) begin
            p_d = n[NBIT-1:0];
            c_d = c_frame;
            // A bad frame is still processed; it only marks the error flag.
            if (|chk_bad) begin
                frame_err_d = 1'b1;
            end
        end

        if (s2_load) begin
            out_valid_d = s1_v_q;
        end
        // Result registers only change when real data moves in.
        // This keeps them quiet while the pipe drains.
        if (s2_load && s1_v_q) begin
            sum_d   = p_q ^ c_q[NBIT-1:0];
            c_out_d = c_q[NBIT];
            ovf_d   = c_q[NBIT] ^ c_q[NBIT-1];
        end

        if (out_xfer) begin
            res_cnt_d = res_cnt_q + CNTW'(1);
        end
    end

    // State registers; reset discards any in-flight frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            p_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            frame_err_q <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            p_q         <= p_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            frame_err_q <= frame_err_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign frame_err = frame_err_q;
    assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_cla_linear_recombine_pipe.sv
// Self-checking bench for cla_linear_recombine_pipe (NBIT=4).
// Frames come from a golden nonlinear model built from a, b and c.
// A negedge monitor scores every delivered result against an expectation queue.
module tb_cla_linear_recombine_pipe;

    localparam int NBIT = 4;
    localparam int NNL  = 19;
    localparam int CNTW = 8;

    typedef struct packed {
        logic [3:0] s;
        logic       co;
        logic       ov;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        res_t       r;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NNL-1:0]  n = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [NBIT-1:0] sum;
    logic            c_out;
    logic            ovf;
    logic            frame_err;
    logic [CNTW-1:0] res_cnt;

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];
    res_t cur_exp = '0;

    always #5 clk = ~clk;

    cla_linear_recombine_pipe #(.NBIT(NBIT), .NNL(NNL), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .frame_err (frame_err),
        .res_cnt   (res_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden nonlinear stage: p, the AND-term carry groups and c_in.
    function automatic logic [NNL-1:0] build_frame(input logic [3:0] a, input logic [3:0] b,
                                                   input logic c);
        logic [3:0]     p;
        logic [3:0]     g;
        logic [NNL-1:0] f;
        logic           t;
        int             off;
        p = a ^ b;
        g = a & b;
        f = '0;
        f[3:0] = p;
        f[NNL-1] = c;
        for (int k = 1; k <= 4; k++) begin
            off = 4 + (k - 1) * (k + 2) / 2;
            for (int j = 0; j < k; j++) begin
                t = g[j];
                for (int m = j + 1; m < k; m++) t = t & p[m];
                f[off + j] = t;
            end
            t = c;
            for (int m = 0; m < k; m++) t = t & p[m];
            f[off + k] = t;
        end
        return f;
    endfunction

    // Arithmetic reference: 4-bit sum, carry out and two's-complement overflow.
    function automatic res_t arith(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] s5;
        res_t       r;
        s5   = {1'b0, a} + {1'b0, b} + {4'b0, c};
        r.s  = s5[3:0];
        r.co = s5[4];
        r.ov = (a[3] == b[3]) && (s5[3] != a[3]);
        return r;
    endfunction

    // Scoreboard: one line per delivered result; push expectations on accept.
    always @(negedge clk) begin
        res_t r;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    $display("result cnt=%0d sum=%0d c_out=%0b ovf=%0b", res_cnt, sum, c_out, ovf);
                    check("result", {26'b0, sum, c_out, ovf}, {26'b0, r});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    // Offer one frame until it is accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [NNL-1:0] f, input res_t e);
        int   k;
        logic acc;
        n        = f;
        cur_exp  = e;
        in_valid = 1'b1;
        k        = 0;
        acc      = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!acc && k < 50);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Wait until every expected result has been delivered.
    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_timeout", (k < 100) ? 32'd1 : 32'd0, 32'd1);
    endtask

    vec_t           tbl[9];
    logic [NNL-1:0] t3f[3];
    res_t           t3e[3];
    logic [NNL-1:0] fbad;
    logic [CNTW-1:0] cnt_before;
    int             idx;
    int             k;
    logic           stale;

    initial begin
        // Hand-computed vectors.
        tbl[0] = '{a: 4'd5,  b: 4'd10, c: 1'b0, r: '{s: 4'd15, co: 1'b0, ov: 1'b0}};
        tbl[1] = '{a: 4'd15, b: 4'd1,  c: 1'b0, r: '{s: 4'd0,  co: 1'b1, ov: 1'b0}};
        tbl[2] = '{a: 4'd5,  b: 4'd3,  c: 1'b0, r: '{s: 4'd8,  co: 1'b0, ov: 1'b1}};
        tbl[3] = '{a: 4'd0,  b: 4'd0,  c: 1'b0, r: '{s: 4'd0,  co: 1'b0, ov: 1'b0}};
        tbl[4] = '{a: 4'd15, b: 4'd15, c: 1'b1, r: '{s: 4'd15, co: 1'b1, ov: 1'b0}};
        tbl[5] = '{a: 4'd7,  b: 4'd0,  c: 1'b1, r: '{s: 4'd8,  co: 1'b0, ov: 1'b1}};
        tbl[6] = '{a: 4'd8,  b: 4'd8,  c: 1'b0, r: '{s: 4'd0,  co: 1'b1, ov: 1'b1}};
        tbl[7] = '{a: 4'd9,  b: 4'd6,  c: 1'b1, r: '{s: 4'd0,  co: 1'b1, ov: 1'b0}};
        tbl[8] = '{a: 4'd6,  b: 4'd1,  c: 1'b1, r: '{s: 4'd8,  co: 1'b0, ov: 1'b1}};

        t3f[0] = build_frame(4'd1, 4'd2, 1'b0);  t3e[0] = '{s: 4'd3,  co: 1'b0, ov: 1'b0};
        t3f[1] = build_frame(4'd7, 4'd7, 1'b0);  t3e[1] = '{s: 4'd14, co: 1'b0, ov: 1'b1};
        t3f[2] = build_frame(4'd12, 4'd4, 1'b1); t3e[2] = '{s: 4'd1,  co: 1'b1, ov: 1'b0};

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", {19'b0, out_valid, sum, c_out, ovf, frame_err, res_cnt},
              32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        // T1: single frame, latency and counter
        out_ready = 1'b1;
        send(build_frame(tbl[0].a, tbl[0].b, tbl[0].c), tbl[0].r);
        check("t1_not_yet_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_result", {25'b0, out_valid, sum, c_out, ovf}, {25'b0, 1'b1, tbl[0].r});
        @(posedge clk);
        #1;
        check("t1_res_cnt", {24'b0, res_cnt}, 32'd1);

        // T2: back-to-back frames, results in consecutive cycles
        send(build_frame(tbl[1].a, tbl[1].b, tbl[1].c), tbl[1].r);
        send(build_frame(tbl[2].a, tbl[2].b, tbl[2].c), tbl[2].r);
        check("t2_first", {25'b0, out_valid, sum, c_out, ovf}, {25'b0, 1'b1, tbl[1].r});
        @(posedge clk);
        #1;
        check("t2_second", {25'b0, out_valid, sum, c_out, ovf}, {25'b0, 1'b1, tbl[2].r});
        drain();

        // Table of directed vectors
        for (int i = 3; i < 9; i++) begin
            send(build_frame(tbl[i].a, tbl[i].b, tbl[i].c), tbl[i].r);
        end
        drain();
        check("table_res_cnt", {24'b0, res_cnt}, 32'd9);

        // T3: stall with three frames offered
        cnt_before = res_cnt;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        idx        = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            n       = t3f[idx];
            cur_exp = t3e[idx];
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
            if (cyc >= 1) begin
                check("t3_hold", {25'b0, out_valid, sum, c_out, ovf}, {25'b0, 1'b1, t3e[0]});
            end
        end
        check("t3_accepted", idx, 32'd2);
        check("t3_in_ready_low", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        k = 0;
        while (idx < 3 && k < 20) begin
            n       = t3f[idx];
            cur_exp = t3e[idx];
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        check("t3_third_accepted", idx, 32'd3);
        drain();
        check("t3_res_cnt", {24'b0, res_cnt}, {24'b0, cnt_before + 8'd3});

        // T4: corrupted frame (6+1+1 with group-3 c_in term cleared)
        check("t4_err_clear", {31'b0, frame_err}, 32'd0);
        fbad = build_frame(4'd6, 4'd1, 1'b1);
        fbad[12] = ~fbad[12];
        send(fbad, '{s: 4'd0, co: 1'b0, ov: 1'b0});
        check("t4_err_set", {31'b0, frame_err}, 32'd1);
        send(build_frame(4'd3, 4'd3, 1'b0), arith(4'd3, 4'd3, 1'b0));
        drain();
        check("t4_err_sticky", {31'b0, frame_err}, 32'd1);

        // T6: reset during a stall that holds two frames
        out_ready = 1'b0;
        send(build_frame(4'd2, 4'd2, 1'b0), arith(4'd2, 4'd2, 1'b0));
        send(build_frame(4'd9, 4'd9, 1'b0), arith(4'd9, 4'd9, 1'b0));
        check("t6_stalled_full", {30'b0, out_valid, in_ready}, 32'd2);
        #3 rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", {19'b0, out_valid, sum, c_out, ovf, frame_err, res_cnt},
              32'd0);
        check("t6_reset_in_ready", {31'b0, in_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale = 1'b1;
        end
        check("t6_no_stale", {31'b0, stale}, 32'd0);
        check("t6_res_cnt", {24'b0, res_cnt}, 32'd0);

        // T5: full a,b,c sweep; counter wrap at 2^CNTW+2
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            send(build_frame(v[3:0], v[7:4], v[8]), arith(v[3:0], v[7:4], v[8]));
            if (i == 257) begin
                drain();
                check("t5_wrap_to_2", {24'b0, res_cnt}, 32'd2);
            end
        end
        drain();
        check("t5_res_cnt_end", {24'b0, res_cnt}, 32'd0);
        check("t5_no_frame_err", {31'b0, frame_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
